// File: rtl/truth_table_sweep_if.sv
// Bus between the truth-table sweeper and the 2-input gate network it exercises.
// Optional log bus (RESULT_LOG_EN) carries the captured {p,q} pairs of the last sweep.
interface truth_table_sweep_if;
    logic       start;
    logic       a;
    logic       b;
    logic       p_in;
    logic       q_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] row;
`ifdef RESULT_LOG_EN
    logic [7:0] log;
`endif

    // master: controller/network side; slave: the sweeper
    modport master (
        output start, p_in, q_in,
        input  a, b, busy, done, pass, err_count, row
`ifdef RESULT_LOG_EN
        , input log
`endif
    );

    modport slave (
        input  start, p_in, q_in,
        output a, b, busy, done, pass, err_count, row
`ifdef RESULT_LOG_EN
        , output log
`endif
    );
endinterface

// File: rtl/truth_table_sweep.sv
// Purpose: drives rows 00,01,10,11 onto a 2-input network, checks q == a^b, counts mismatches (RESULT_LOG_EN adds {p,q} log).
// Latency: start accepted at edge T -> done pulse in cycle T+4*(HOLD+1)+1.
// Backpressure: none; start is ignored unless IDLE, no queuing.
module truth_table_sweep #(
    parameter int unsigned HOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_sweep_if.slave   sweep
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic [1:0] row_q;
    logic [2:0] err_q;
    logic [2:0] err_nxt;
    logic       pass_q;
    logic       accept;
    logic       mismatch;
`ifdef RESULT_LOG_EN
    logic [7:0] log_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (sweep.start) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE:  if (hold_cnt == 4'd0) state_nxt = SAMPLE;
            SAMPLE: state_nxt = (row_q == 2'd3) ? DONE : DRIVE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // a,b are the row register itself, so they only move when the row advances
    assign mismatch = sweep.q_in != (row_q[1] ^ row_q[0]);
    assign err_nxt  = err_q + {2'b00, mismatch};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= 4'd0;
            row_q    <= 2'd0;
            err_q    <= 3'd0;
            pass_q   <= 1'b0;
`ifdef RESULT_LOG_EN
            log_q    <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_cnt <= HOLD_LOAD;
                        row_q    <= 2'd0;
                        err_q    <= 3'd0;
                        pass_q   <= 1'b0;
`ifdef RESULT_LOG_EN
                        log_q    <= 8'd0;
`endif
                    end
                end
                DRIVE: begin
                    if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
                end
                SAMPLE: begin
                    err_q <= err_nxt;
`ifdef RESULT_LOG_EN
                    log_q[{row_q, 1'b0} +: 2] <= {sweep.p_in, sweep.q_in};
`endif
                    if (row_q != 2'd3) begin
                        row_q    <= row_q + 2'd1;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        // pass is settled on entry to DONE so it is valid alongside the done pulse
                        pass_q <= (err_nxt == 3'd0);
                    end
                end
                DONE: row_q <= 2'd0;
                default: row_q <= 2'd0;
            endcase
        end
    end

    assign sweep.a         = row_q[1];
    assign sweep.b         = row_q[0];
    assign sweep.row       = row_q;
    assign sweep.busy      = (state == DRIVE) || (state == SAMPLE);
    assign sweep.done      = (state == DONE);
    assign sweep.pass      = pass_q;
    assign sweep.err_count = err_q;
`ifdef RESULT_LOG_EN
    assign sweep.log       = log_q;
`endif

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter: HOLD, default 2, number of settle cycles each input row is driven before q is sampled (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one full sweep; honoured only in IDLE.
REQ-005 a  output  1  stimulus bit a to the 2-input gate network under test.
REQ-006 b  output  1  stimulus bit b to the 2-input gate network under test.
REQ-007 p_in  input  1  network output p; captured, not checked.
REQ-008 q_in  input  1  network output q; checked against a XOR b.
REQ-009 busy  output  1  high in DRIVE and SAMPLE.
REQ-010 done  output  1  one-cycle pulse when the sweep completes.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 err_count  output  3  mismatches in current/last sweep, 0..4.
REQ-013 row  output  2  current row index; a = row[1], b = row[0].

Function
REQ-014 States: IDLE, DRIVE, SAMPLE, DONE; registered state, one-hot or binary at implementer's choice.
REQ-015 IDLE: a=b=0, row=0, busy=0; start=1 -> DRIVE, clear err_count and pass, load hold counter with HOLD-1.
REQ-016 DRIVE: a,b driven from row; counter decrements each cycle; counter=0 -> SAMPLE.
REQ-017 SAMPLE (exactly 1 cycle): mismatch if q_in != (a XOR b); mismatch increments err_count by 1.
REQ-018 SAMPLE with row<3 -> row+1, reload counter, DRIVE; row=3 -> DONE.
REQ-019 Row order fixed: 00, 01, 10, 11; a,b change only on the SAMPLE->DRIVE transition.
REQ-020 DONE (1 cycle): done=1, pass=(err_count==0) registered; next state IDLE.
REQ-021 Latency: start accepted at edge T -> done high in cycle T+4*(HOLD+1)+1 (HOLD=2: 13 cycles).
REQ-022 err_count, pass hold their values after DONE until the next accepted start.
REQ-023 start while busy or in DONE is ignored; no queuing, no restart.
REQ-024 err_count never exceeds 4; no wrap logic required beyond 3-bit width.
REQ-025 p_in, q_in treated as synchronous to clk; sampled only in SAMPLE.

Reset
REQ-026 reset=1 forces immediately: state IDLE, a=0, b=0, row=0, busy=0, done=0, pass=0, err_count=0, counter=0 (and log=0 when enabled).
REQ-027 Reset mid-sweep aborts without a done pulse; next start performs a full fresh sweep.

Configuration
REQ-028 Macro RESULT_LOG_EN: when defined, adds output log (8 bits); bits [2r+1:2r] = {p_in,q_in} captured in SAMPLE of row r; cleared on accepted start.
REQ-029 Without RESULT_LOG_EN: no log port, no log registers; all other behaviour identical.

Verification
REQ-030 HOLD=2, q_in = a XOR b: start pulse -> a,b sequence 00,01,10,11 each 3 cycles, done at cycle 13, pass=1, err_count=0.
REQ-031 q_in stuck at 0 -> err_count=2, pass=0 at done.
REQ-032 q_in = a XNOR b -> err_count=4, pass=0.
REQ-033 start re-asserted at cycle 5 of a sweep -> ignored; single done at cycle 13.
REQ-034 reset asserted while row=2 -> a=b=0, busy=0, err_count=0, no done; new start -> full sweep, done 13 cycles later.
REQ-035 RESULT_LOG_EN, p_in=1, q_in = a XOR b -> log=8'hBE at done.
